// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_pkg
// Purpose  : Shared types and constants for the data-bus arbiter.
//            - state_t      : arbiter FSM state (IDLE / OWN / TURN)
//            - REQ_*        : fixed requester index assignment on req/lock/d/oe
// Revision : 1.0  initial release
// ============================================================================
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no holder, bus undriven
        OWN  = 2'd1,   // exactly one holder, oe one-hot
        TURN = 2'd2    // one dead cycle between different holders
    } state_t;

    localparam int REQ_RF  = 0;
    localparam int REQ_ALU = 1;
    localparam int REQ_LSU = 2;
    localparam int REQ_ADU = 3;
    localparam int REQ_ECU = 4;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotating-priority picker. The search starts at
//            i_ptr and wraps modulo N; the first asserted request wins.
// Ports    : i_req   [N-1:0]          request vector
//            i_ptr   [$clog2(N)-1:0]  index with the highest priority
//            o_gnt   [N-1:0]          one-hot winner (zero when none)
//            o_valid                  at least one request present
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic                 o_valid
);

    localparam int c_pw = $clog2(N);

    logic [c_pw-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            // Candidate i positions after the pointer, wrapped into range.
            w_idx = c_pw'((int'(i_ptr) + i) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbus_arb.sv
`default_nettype none
// ============================================================================
// Module   : dbus_arb
// Purpose  : Arbiter and multiplexer for the shared 8-bit CPU data bus.
//            Produces a registered one-hot output enable (or none) and the
//            single driven bus value. A dead TURN cycle separates grants to
//            different holders; the PRIO_IDX requester overrides round-robin.
// Ports    : clk, rst            clock / synchronous active-high reset
//            req    [N_REQ]      level requests
//            lock   [N_REQ]      holder keeps the bus next cycle
//            d      [N_REQ*8]    requester data, slice k = d[8k+7:8k]
//            oe     [N_REQ]      registered one-hot grant
//            db     [8]          selected data, 8'h00 when idle
//            busy                |oe
//            gnt_id [clog2]      holder index, valid while busy
//            err                 pulse after a watchdog forced release
// Config   : DBUS_ARB_WATCHDOG_EN  enables the MAX_LOCK watchdog and err
// Revision : 1.0  initial release
// ============================================================================
module dbus_arb
    import dbus_pkg::*;
#(
    parameter int N_REQ    = 5,
    parameter int PRIO_IDX = REQ_ECU,
    parameter int MAX_LOCK = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ*8-1:0]         d,
    output logic [N_REQ-1:0]           oe,
    output logic [7:0]                 db,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic                       err
);

    localparam int                  c_id_w    = $clog2(N_REQ);
    localparam logic [c_id_w-1:0]   c_prio_id = c_id_w'(PRIO_IDX);
    localparam logic [c_id_w-1:0]   c_last_id = c_id_w'(N_REQ - 1);
    localparam logic [N_REQ-1:0]    c_one     = N_REQ'(1);

    if (MAX_LOCK < 2) begin : g_bad_max_lock
        $error("dbus_arb: MAX_LOCK must be at least 2");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state,   w_state_nxt;
    logic [N_REQ-1:0]    r_oe,      w_oe_nxt;
    // Holder while in OWN; latched winner while in TURN.
    logic [c_id_w-1:0]   r_gnt_id,  w_gnt_id_nxt;
    logic [c_id_w-1:0]   r_rr_ptr,  w_rr_ptr_nxt;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [c_id_w-1:0]   w_ptr_eff;
    logic [N_REQ-1:0]    w_rr_gnt;
    logic                w_any;
    logic [c_id_w-1:0]   w_rr_id;
    logic [c_id_w-1:0]   w_win_id;
    logic                w_wd_limit;
    logic                w_cont;

    // At a holder's final cycle the search already ranks that holder last,
    // i.e. it uses the pointer value being committed this cycle. Grants to
    // the priority requester are outside the rotation and leave the pointer
    // alone, so the rotation among the others resumes where it stopped.
    always_comb begin
        w_ptr_eff = r_rr_ptr;
        if (r_state == OWN && r_gnt_id != c_prio_id) begin
            w_ptr_eff = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + c_id_w'(1);
        end
    end

    rr_pick #(
        .N       (N_REQ)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (w_ptr_eff),
        .o_gnt   (w_rr_gnt),
        .o_valid (w_any)
    );

    always_comb begin
        w_rr_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_rr_gnt[k]) begin
                w_rr_id = c_id_w'(k);
            end
        end
    end

    always_comb begin
        w_win_id = w_rr_id;
        if (req[PRIO_IDX]) begin
            w_win_id = c_prio_id;
        end
    end

    // The grant carries into the next cycle only while the holder keeps
    // both req and lock and the watchdog has not expired.
    assign w_cont = req[r_gnt_id] & lock[r_gnt_id] & ~w_wd_limit;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_oe     <= '0;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_oe     <= w_oe_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_oe_nxt     = r_oe;
        w_gnt_id_nxt = r_gnt_id;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = OWN;
                    w_oe_nxt     = c_one << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                end
            end
            OWN: begin
                if (!w_cont) begin
                    // Final grant cycle: arbitration point.
                    w_rr_ptr_nxt = w_ptr_eff;
                    if (!w_any) begin
                        w_state_nxt = IDLE;
                        w_oe_nxt    = '0;
                    end else if (w_win_id != r_gnt_id) begin
                        w_state_nxt  = TURN;
                        w_oe_nxt     = '0;
                        w_gnt_id_nxt = w_win_id;
                    end
                    // Same winner: back-to-back re-grant, oe unchanged.
                end
            end
            TURN: begin
                // Winner was latched at the arbitration point; new
                // requests seen during the dead cycle are ignored.
                w_state_nxt = OWN;
                w_oe_nxt    = c_one << r_gnt_id;
            end
            default: begin
                w_state_nxt = IDLE;
                w_oe_nxt    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef DBUS_ARB_WATCHDOG_EN
    localparam int c_cnt_w = $clog2(MAX_LOCK + 1);

    // Number of cycles the current grant has been held, including the
    // present one; zero whenever nobody owns the bus.
    logic [c_cnt_w-1:0] r_wd_cnt;
    logic               r_err;

    assign w_wd_limit = (r_wd_cnt == c_cnt_w'(MAX_LOCK));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == OWN && w_cont) begin
                r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
            end else if (w_state_nxt == OWN) begin
                r_wd_cnt <= c_cnt_w'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            // Flag only releases the holder did not ask for.
            r_err <= (r_state == OWN) && req[r_gnt_id] && lock[r_gnt_id]
                     && w_wd_limit;
        end
    end

    assign err = r_err;
`else
    assign w_wd_limit = 1'b0;
    assign err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs and data mux
    // ------------------------------------------------------------------
    assign oe     = r_oe;
    assign busy   = |r_oe;
    assign gnt_id = r_gnt_id;

    // AND-OR mux: with oe one-hot or zero, at most one slice contributes.
    always_comb begin
        db = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_oe[k]) begin
                db = db | d[k*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire
